// File: rtl/aux_if.sv
// aux_if: multi-flop synchronizer that brings the asynchronous auxiliary input bus into sys_clk
module aux_if #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [DW-1:0] aux_in,
  output logic [DW-1:0] aux_i
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $fatal(1, "aux_if: SYNC_STAGES must be in 2..4");
  end
  logic [SYNC_STAGES-1:0][DW-1:0] stage_q, stage_d;
  always_comb stage_d = {stage_q[SYNC_STAGES-2:0], aux_in};
  always_ff @(posedge sys_clk) begin
    if (sys_rst) stage_q <= '0;
    else stage_q <= stage_d;
  end
  assign aux_i = stage_q[SYNC_STAGES-1];
endmodule

// File: tb/tb_aux_if.sv
// tb_aux_if: directed checks of the aux_if synchronizer at 2, 3 and 4 stages
module tb_aux_if;
  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] aux_in = '0;
  logic [31:0] y2, y3, y4;
  int checks = 0;
  int errors = 0;

  aux_if #(.DW(32), .SYNC_STAGES(2)) dut2 (.sys_clk(clk), .sys_rst(sys_rst), .aux_in(aux_in), .aux_i(y2));
  aux_if #(.DW(32), .SYNC_STAGES(3)) dut3 (.sys_clk(clk), .sys_rst(sys_rst), .aux_in(aux_in), .aux_i(y3));
  aux_if #(.DW(32), .SYNC_STAGES(4)) dut4 (.sys_clk(clk), .sys_rst(sys_rst), .aux_in(aux_in), .aux_i(y4));

  always #5 clk = ~clk;

  // Inputs change on negedge; outputs only move on posedge, so reading right after is stable.
  task automatic drive(input logic r, input logic [31:0] d);
    @(negedge clk);
    sys_rst = r;
    aux_in = d;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'h0);
    drive(1'b1, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] vals [3];
    vals = '{32'd125, 32'd134, 32'd198};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i]);
      checks++;
      if (y2 !== 32'h0 || y3 !== 32'h0 || y4 !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %h/%h/%h exp 0", i, y2, y3, y4);
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp;
    do_reset();
    drive(1'b0, 32'h0000_007D);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 32'h0000_007D);
      exp = (k >= 2) ? 32'h7D : 32'h0;
      checks++;
      if (y2 !== exp) begin
        errors++;
        $display("FAIL latency2 after %0d edges got %h exp %h", k, y2, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp = '{32'd0, 32'd134, 32'd198, 32'd0};
    do_reset();
    drive(1'b0, 32'd134);
    drive(1'b0, 32'd198);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(1'b0, 32'd0);
      checks++;
      if (y2 !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %0d exp %0d", i, y2, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 32'hFFFF_FFFF);
    checks++;
    if (y2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mid_reset_prefill got %h exp ffffffff", y2);
    end
    drive(1'b1, 32'hFFFF_FFFF);
    drive(1'b0, 32'hFFFF_FFFF);
    checks++;
    if (y2 !== 32'h0 || y3 !== 32'h0 || y4 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_clear got %h/%h/%h exp 0", y2, y3, y4);
    end
    drive(1'b0, 32'hFFFF_FFFF);
    checks++;
    if (y2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_release1 got %h exp 0", y2);
    end
    drive(1'b0, 32'hFFFF_FFFF);
    checks++;
    if (y2 !== 32'hFFFF_FFFF || y3 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_release2 got %h/%h exp ffffffff/0", y2, y3);
    end
  endtask

  task automatic test_walking();
    logic [31:0] v [33];
    logic [31:0] e2, e3;
    v[0] = 32'hFFFF_FFFF;
    for (int k = 0; k < 32; k++) v[k+1] = 32'h1 << k;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      drive(1'b0, (i < 33) ? v[i] : 32'h0);
      e2 = (i >= 2 && i - 2 < 33) ? v[i-2] : 32'h0;
      e3 = (i >= 3 && i - 3 < 33) ? v[i-3] : 32'h0;
      checks++;
      if (y2 !== e2 || y3 !== e3) begin
        errors++;
        $display("FAIL walking[%0d] got %h/%h exp %h/%h", i, y2, y3, e2, e3);
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] e3, e4;
    do_reset();
    drive(1'b0, 32'h0000_007D);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 32'h0000_007D);
      e3 = (k >= 3) ? 32'h7D : 32'h0;
      e4 = (k >= 4) ? 32'h7D : 32'h0;
      checks++;
      if (y3 !== e3 || y4 !== e4) begin
        errors++;
        $display("FAIL sweep after %0d edges got %h/%h exp %h/%h", k, y3, y4, e3, e4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_mid_reset();
    test_walking();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
